// File: rtl/pulse_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_scheduler
// Brief    : Arbitrated, clocked pulse-burst engine shared by NREQ requesters.
//            Round-robin by default; define PULSE_BURST_SCHED_FIXED_PRIO_EN
//            for fixed lowest-index-wins priority.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int WW   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] cnt_in,
    input  logic [WW-1:0]      high_w,
    input  logic [WW-1:0]      low_w,
    output logic [NREQ-1:0]    gnt,
    output logic [2:0]         owner,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic               signal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     rem;
    logic [WW-1:0]     ph;
    logic [WW-1:0]     lat_h;
    logic [WW-1:0]     lat_l;

    logic              any_req;
    logic [2:0]        pick;
    logic [NREQ-1:0]   pick_oh;
    logic [CW-1:0]     pick_cnt;
    logic              own_req;
    logic [WW-1:0]     h_eff;
    logic [WW-1:0]     l_eff;

    assign any_req = |req;
    assign own_req = |(req & gnt);
    assign h_eff   = (high_w == '0) ? WW'(1) : high_w;
    assign l_eff   = (low_w  == '0) ? WW'(1) : low_w;

`ifdef PULSE_BURST_SCHED_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) pick = 3'(i);
        end
    end
`else
    logic [2:0] ptr;
    logic [3:0] rr_idx;
    logic [7:0] req_ext;
    logic       found;

    assign req_ext = 8'(req);

    // Search ptr+1, ptr+2, ... with wrap; first set request wins.
    always_comb begin
        pick   = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = {1'b0, ptr} + 4'(i);
            if (rr_idx >= 4'(NREQ)) rr_idx = rr_idx - 4'(NREQ);
            if (!found && req_ext[rr_idx[2:0]]) begin
                found = 1'b1;
                pick  = rr_idx[2:0];
            end
        end
    end
`endif

    always_comb begin
        pick_oh  = '0;
        pick_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 3'(i)) begin
                pick_oh[i] = 1'b1;
                pick_cnt   = cnt_in[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            signal <= 1'b0;
            busy   <= 1'b0;
            owner  <= '0;
            rem    <= '0;
            ph     <= '0;
            lat_h  <= '0;
            lat_l  <= '0;
`ifndef PULSE_BURST_SCHED_FIXED_PRIO_EN
            ptr    <= 3'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    done   <= '0;
                    signal <= 1'b0;
                    if (any_req) begin
                        gnt   <= pick_oh;
                        owner <= pick;
                        busy  <= 1'b1;
                        rem   <= pick_cnt;
                        lat_h <= h_eff;
                        lat_l <= l_eff;
`ifndef PULSE_BURST_SCHED_FIXED_PRIO_EN
                        ptr   <= pick;
`endif
                        if (pick_cnt == '0) begin
                            state <= DONE;
                            done  <= pick_oh;
                        end else begin
                            state  <= HIGH;
                            signal <= 1'b1;
                            ph     <= h_eff - WW'(1);
                        end
                    end
                end
                HIGH: begin
                    if (!own_req) begin
                        state  <= IDLE;
                        signal <= 1'b0;
                        gnt    <= '0;
                        busy   <= 1'b0;
                    end else if (ph == '0) begin
                        state  <= LOW;
                        signal <= 1'b0;
                        ph     <= lat_l - WW'(1);
                    end else begin
                        ph <= ph - WW'(1);
                    end
                end
                LOW: begin
                    if (!own_req) begin
                        state  <= IDLE;
                        signal <= 1'b0;
                        gnt    <= '0;
                        busy   <= 1'b0;
                    end else if (ph == '0) begin
                        rem <= rem - CW'(1);
                        if (rem == CW'(1)) begin
                            state <= DONE;
                            done  <= gnt;
                        end else begin
                            state  <= HIGH;
                            signal <= 1'b1;
                            ph     <= lat_h - WW'(1);
                        end
                    end else begin
                        ph <= ph - WW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pulse_burst_scheduler.md
Name: pulse_burst_scheduler

Overview:
- Shares one synchronous pulse-train engine among NREQ requesters.
- A round-robin arbiter grants the engine to one requester at a time.
- The engine emits a burst of cnt_in[owner] pulses: high for HIGH_W cycles, then low for LOW_W cycles.
- Sits between the clock generator and pulse consumers; it replaces free-running delay-based pulse generators with a clocked, arbitrated source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 4, width of each per-requester pulse count.
- WW, 4, width of the high/low phase-length inputs.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- req  input  NREQ  per-requester burst request; level, held until done.
- cnt_in  input  NREQ*CW  packed pulse counts; requester i uses bits [i*CW +: CW].
- high_w  input  WW  high-phase length in cycles, shared by all requesters.
- low_w  input  WW  low-phase length in cycles, shared by all requesters.
- gnt  output  NREQ  one-hot grant; asserted while the requester owns the engine.
- owner  output  3  index of the current/last granted requester.
- busy  output  1  engine not idle.
- done  output  NREQ  one-cycle completion strobe to the owner.
- signal  output  1  registered pulse-train output.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gnt=0, done=0, signal=0, busy=0, owner=0.
  - Round-robin pointer set to NREQ-1, so requester 0 wins first.
  - Reset mid-burst forces these values immediately; no done is issued.
- States: IDLE, HIGH, LOW, DONE.
- IDLE:
  - If any req bit is 1 at posedge, grant the first set bit searching from pointer+1 upward with wrap-around.
  - On that edge: gnt[k]=1, owner=k, pointer=k, busy=1.
  - Latch cnt_in[k] into the remaining-pulse counter.
  - Latch high_w and low_w; later changes to these inputs do not affect the running burst.
- Zero count: if the latched count is 0, go IDLE→DONE with signal held at 0.
- Otherwise go IDLE→HIGH with signal=1 on the same edge. Latency from req to first high is 1 edge.
- Phase lengths:
  - Effective high length H = max(high_w,1); effective low length L = max(low_w,1).
- HIGH: signal=1 for exactly H cycles, then →LOW with signal=0.
- LOW: signal=0 for exactly L cycles. At the end, decrement the remaining count.
  - Remaining count nonzero: →HIGH.
  - Remaining count zero: →DONE.
- DONE: lasts one cycle.
  - done[owner]=1, gnt still asserted, signal=0.
  - Next edge: gnt=0, busy=0, →IDLE.
- Burst length: total cycles from the first high to DONE entry = count*(H+L).
- Abort: if req[owner] drops while in HIGH or LOW:
  - Next edge: signal=0, gnt=0, busy=0, →IDLE.
  - No done strobe.
  - Pointer remains at the aborted owner.
- Re-arbitration:
  - A requester still holding req after its done is re-arbitrated in IDLE.
  - The pointer has advanced, so other pending requesters win first.
  - Minimum gap between bursts: 1 IDLE cycle.
- Simultaneous requests in IDLE: exactly one grant. The others wait; their req must stay high.
- Invariants:
  - gnt is always one-hot or zero.
  - done is never asserted outside DONE.
  - signal never glitches; it is a flop output.

Optional Feature:
- Macro: PULSE_BURST_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority arbitration; the lowest index always wins, and the pointer is unused.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single requester: req[0]=1, cnt_in[0]=3, high_w=2, low_w=3.
  - signal = 11000 ×3 (15 cycles) starting 1 edge after req.
  - done[0] pulses on cycle 16; gnt[0] drops the following edge.
- Round-robin: req=4'b1111 held high, cnt=1 each, high_w=1, low_w=1.
  - Grant order 0,1,2,3,0.
  - Each grant lasts 3 cycles, separated by 1 IDLE cycle.
- Zero and clamp cases:
  - cnt_in[2]=0: signal stays 0; done[2] fires 1 cycle after the grant.
  - high_w=0, low_w=0, cnt=2: signal pattern 1010.
- Abort: req[1] dropped during the second high phase (cnt=4, high_w=3, low_w=3).
  - signal=0 and gnt=0 on the next edge; done stays 0.
- Asynchronous reset: assert reset=0 mid-LOW between clock edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with req[0]=1, a fresh burst starts on requester 0.
- Fixed priority (macro defined): req=4'b1010 held high.
  - Requester 1 wins repeatedly; requester 3 never granted while req[1]=1.
